// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared opcode, direction, field and FSM definitions for the player executor
package player_pkg;

  localparam int OPC_HI = 15;
  localparam int OPC_LO = 12;
  localparam int ARG_HI = 11;
  localparam int ARG_LO = 4;

  localparam logic [3:0] OPC_NOP = 4'd0;
  localparam logic [3:0] OPC_HPY = 4'd1;
  localparam logic [3:0] OPC_DPY = 4'd2;
  localparam logic [3:0] OPC_IDG = 4'd3;
  localparam logic [3:0] OPC_SDG = 4'd4;
  localparam logic [3:0] OPC_MOV = 4'd5;
  localparam logic [3:0] OPC_SHP = 4'd6;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    INVULN = 1'b1
  } state_t;

  // Signed intermediate lets a step below zero clamp correctly instead of wrapping.
  function automatic logic [9:0] clamp_axis(input logic signed [10:0] v, input int lo, input int hi);
    if (int'(v) < lo) return 10'(lo);
    if (int'(v) > hi) return 10'(hi);
    return 10'(v);
  endfunction

endpackage

// File: rtl/player_executor_if.sv
// rtl/player_executor_if.sv - instruction/status bundle between control FSM and player executor
interface player_executor_if;
  logic [15:0] playerInstruction;
  logic        isMove;
  logic        startDmg;
  logic [7:0]  hp;
  logic [9:0]  pos_x;
  logic [9:0]  pos_y;
  logic        isDeath;
  logic        dmg_done;
  logic        invuln;

  modport master (
    output playerInstruction, isMove, startDmg,
    input  hp, pos_x, pos_y, isDeath, dmg_done, invuln
  );

  modport slave (
    input  playerInstruction, isMove, startDmg,
    output hp, pos_x, pos_y, isDeath, dmg_done, invuln
  );
endinterface

// File: rtl/hp_sat_alu.sv
// rtl/hp_sat_alu.sv - combinational saturating heal/damage arithmetic
module hp_sat_alu (
  input  logic [7:0] hp,
  input  logic [7:0] operand,
  input  logic       op_heal,
  input  logic [7:0] max_hp,
  output logic [7:0] new_hp,
  output logic       zero
);
  logic [8:0] sum;

  always_comb begin
    sum = {1'b0, hp} + {1'b0, operand};
    if (op_heal) begin
      new_hp = (sum > {1'b0, max_hp}) ? max_hp : sum[7:0];
    end else begin
      new_hp = (operand >= hp) ? 8'd0 : hp - operand;
    end
    zero = (new_hp == 8'd0);
  end
endmodule

// File: rtl/player_executor.sv
// rtl/player_executor.sv - decodes player instructions: HP changes, invulnerability window, clamped movement
module player_executor
  import player_pkg::*;
#(
  parameter int MAX_HP        = 100,
  parameter int BOX_X_MIN     = 220,
  parameter int BOX_X_MAX     = 420,
  parameter int BOX_Y_MIN     = 260,
  parameter int BOX_Y_MAX     = 420,
  parameter int MOVE_STEP     = 2,
  parameter int MOVE_DIV      = 250000,
  parameter int INVULN_CYCLES = 50000000
) (
  input  logic clk,
  input  logic reset,
  player_executor_if.slave bus
);
  localparam logic [7:0]         MAX_HP_V    = 8'(MAX_HP);
  localparam logic [9:0]         CENTRE_X    = 10'((BOX_X_MIN + BOX_X_MAX) / 2);
  localparam logic [9:0]         CENTRE_Y    = 10'((BOX_Y_MIN + BOX_Y_MAX) / 2);
  localparam logic signed [10:0] STEP_S      = 11'(MOVE_STEP);
  localparam logic [31:0]        MOVE_RELOAD = 32'(MOVE_DIV - 1);
  localparam logic [31:0]        INV_RELOAD  = 32'(INVULN_CYCLES - 1);

  logic [3:0]  opc;
  logic [7:0]  arg;
  logic        unused_low_bits;
  logic        is_shp, is_hpy, is_dpy, is_mov;

  state_t      state;
  logic        alive;
  logic [7:0]  hp_r;
  logic [9:0]  pos_x_r, pos_y_r;
  logic        death_r, dmg_done_r, invuln_r;
  logic [31:0] move_cnt, inv_cnt;

  logic [7:0]  alu_hp;
  logic        alu_zero;
  logic signed [10:0] sx, sy;
  logic [9:0]  next_x, next_y;

  assign opc             = bus.playerInstruction[OPC_HI:OPC_LO];
  assign arg             = bus.playerInstruction[ARG_HI:ARG_LO];
  assign unused_low_bits = ^bus.playerInstruction[3:0];

  always_comb begin
    is_shp = 1'b0;
    is_hpy = 1'b0;
    is_dpy = 1'b0;
    is_mov = 1'b0;
    case (opc)
      OPC_SHP: is_shp = 1'b1;
      OPC_HPY: is_hpy = 1'b1;
      OPC_DPY: is_dpy = 1'b1;
      OPC_MOV: is_mov = 1'b1;
      OPC_IDG, OPC_SDG, OPC_NOP: ;
      default: ;
    endcase
  end

  hp_sat_alu u_alu (
    .hp      (hp_r),
    .operand (arg),
    .op_heal (is_hpy),
    .max_hp  (MAX_HP_V),
    .new_hp  (alu_hp),
    .zero    (alu_zero)
  );

  always_comb begin
    sx = $signed({1'b0, pos_x_r});
    sy = $signed({1'b0, pos_y_r});
    case (arg[1:0])
      DIR_UP:    sy = sy - STEP_S;
      DIR_LEFT:  sx = sx - STEP_S;
      DIR_DOWN:  sy = sy + STEP_S;
      DIR_RIGHT: sx = sx + STEP_S;
      default: ;
    endcase
    next_x = clamp_axis(sx, BOX_X_MIN, BOX_X_MAX);
    next_y = clamp_axis(sy, BOX_Y_MIN, BOX_Y_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      alive      <= 1'b0;
      hp_r       <= 8'd0;
      pos_x_r    <= CENTRE_X;
      pos_y_r    <= CENTRE_Y;
      death_r    <= 1'b0;
      dmg_done_r <= 1'b0;
      invuln_r   <= 1'b0;
      move_cnt   <= '0;
      inv_cnt    <= '0;
    end else begin
      dmg_done_r <= 1'b0;
      if (is_shp) begin
        hp_r     <= (arg > MAX_HP_V) ? MAX_HP_V : arg;
        pos_x_r  <= CENTRE_X;
        pos_y_r  <= CENTRE_Y;
        death_r  <= 1'b0;
        alive    <= 1'b1;
        state    <= IDLE;
        invuln_r <= 1'b0;
        inv_cnt  <= '0;
        move_cnt <= '0;
      end else begin
        if (state == INVULN) begin
          if (inv_cnt == '0) begin
            state    <= IDLE;
            invuln_r <= 1'b0;
          end else begin
            inv_cnt <= inv_cnt - 32'd1;
          end
        end

        // Heals are honoured mid-window; damage only lands from IDLE.
        if (bus.startDmg && alive && is_hpy) begin
          hp_r       <= alu_hp;
          dmg_done_r <= 1'b1;
        end
        if (bus.startDmg && alive && is_dpy && state == IDLE) begin
          hp_r       <= alu_hp;
          dmg_done_r <= 1'b1;
          if (alu_zero) begin
            death_r <= 1'b1;
            alive   <= 1'b0;
          end else begin
            state    <= INVULN;
            invuln_r <= 1'b1;
            inv_cnt  <= INV_RELOAD;
          end
        end

        if (is_mov && bus.isMove) begin
          if (move_cnt == '0) begin
            if (alive) begin
              pos_x_r <= next_x;
              pos_y_r <= next_y;
            end
            move_cnt <= MOVE_RELOAD;
          end else begin
            move_cnt <= move_cnt - 32'd1;
          end
        end else begin
          move_cnt <= '0;
        end
      end
    end
  end

  assign bus.hp       = hp_r;
  assign bus.pos_x    = pos_x_r;
  assign bus.pos_y    = pos_y_r;
  assign bus.isDeath  = death_r;
  assign bus.dmg_done = dmg_done_r;
  assign bus.invuln   = invuln_r;
endmodule

// File: tb/tb_player_executor.sv
// tb/tb_player_executor.sv - scoreboard bench for player_executor with directed vectors
module tb_player_executor;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  player_executor_if bus();

  player_executor #(
    .MAX_HP(100), .BOX_X_MIN(220), .BOX_X_MAX(420), .BOX_Y_MIN(260), .BOX_Y_MAX(420),
    .MOVE_STEP(2), .MOVE_DIV(4), .INVULN_CYCLES(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    string      name;
    logic [7:0] hp;
    logic [9:0] x;
    logic [9:0] y;
    logic       death;
    logic       done;
    logic       inv;
  } exp_t;

  exp_t sb[$];

  function automatic logic [15:0] mk(input logic [3:0] opc, input logic [7:0] arg);
    return {opc, arg, 4'hA};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic go(input string name, input logic [15:0] ins, input logic mv, input logic sd,
                    input logic rst, input int hp, input int x, input int y,
                    input logic death, input logic done, input logic inv);
    exp_t e;
    @(posedge clk);
    #1;
    bus.playerInstruction = ins;
    bus.isMove            = mv;
    bus.startDmg          = sd;
    reset                 = rst;
    e.cyc = cyc + 1; e.name = name;
    e.hp = 8'(hp); e.x = 10'(x); e.y = 10'(y);
    e.death = death; e.done = done; e.inv = inv;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.cyc != cyc) begin
        errors++;
        $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else if ({bus.hp, bus.pos_x, bus.pos_y, bus.isDeath, bus.dmg_done, bus.invuln} !==
                   {e.hp, e.x, e.y, e.death, e.done, e.inv}) begin
        errors++;
        $display("FAIL %s @%0d: got hp=%0d x=%0d y=%0d death=%b done=%b inv=%b, want hp=%0d x=%0d y=%0d death=%b done=%b inv=%b",
                 e.name, cyc, bus.hp, bus.pos_x, bus.pos_y, bus.isDeath, bus.dmg_done, bus.invuln,
                 e.hp, e.x, e.y, e.death, e.done, e.inv);
      end
    end
  end

  localparam logic [3:0] HPY = 4'd1, DPY = 4'd2, IDG = 4'd3, MOV = 4'd5, SHP = 4'd6;

  initial begin
    int ex;
    bus.playerInstruction = 16'h0000;
    bus.isMove = 1'b0;
    bus.startDmg = 1'b0;

    go("reset_a", 16'h0000, 0, 0, 1, 0, 320, 340, 0, 0, 0);
    go("reset_b", 16'h0000, 0, 0, 1, 0, 320, 340, 0, 0, 0);

    // Set HP, take a hit, then ride out the invulnerability window.
    go("shp100", mk(SHP, 8'd100), 0, 0, 0, 100, 320, 340, 0, 0, 0);
    go("dpy30",  mk(DPY, 8'd30),  0, 1, 0,  70, 320, 340, 0, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      go((k == 3) ? "dpy_in_invuln" : "invuln_window",
         (k == 3) ? mk(DPY, 8'd30) : 16'h0000, 0, (k == 3), 0, 70, 320, 340, 0, 0, (k < 8));
    end
    go("dpy80_death", mk(DPY, 8'd80), 0, 1, 0, 0, 320, 340, 1, 1, 0);
    go("dead_dpy",    mk(DPY, 8'd10), 0, 1, 0, 0, 320, 340, 1, 0, 0);
    go("dead_hpy",    mk(HPY, 8'd50), 0, 1, 0, 0, 320, 340, 1, 0, 0);
    for (int k = 0; k < 3; k++) go("dead_move", mk(MOV, 8'd3), 1, 0, 0, 0, 320, 340, 1, 0, 0);

    // Heal saturation, including the 9-bit carry path and SHP clamp.
    go("shp95",        mk(SHP, 8'd95),  0, 0, 0,  95, 320, 340, 0, 0, 0);
    go("hpy10_sat",    mk(HPY, 8'd10),  0, 1, 0, 100, 320, 340, 0, 1, 0);
    go("shp1",         mk(SHP, 8'd1),   0, 0, 0,   1, 320, 340, 0, 0, 0);
    go("hpy255_sat",   mk(HPY, 8'd255), 0, 1, 0, 100, 320, 340, 0, 1, 0);
    go("shp200_clamp", mk(SHP, 8'd200), 0, 0, 0, 100, 320, 340, 0, 0, 0);

    go("strobe_mov", mk(MOV, 8'd3),  0, 1, 0, 100, 320, 340, 0, 0, 0);
    go("strobe_idg", mk(IDG, 8'd50), 0, 1, 0, 100, 320, 340, 0, 0, 0);

    // Hold right: a step on cycle 1 and every 4th cycle, stopping at the box edge.
    for (int j = 1; j <= 400; j++) begin
      ex = 320 + 2 * ((j - 1) / 4 + 1);
      if (ex > 420) ex = 420;
      go("mov_right", mk(MOV, 8'd3), 1, 0, 0, 100, ex, 340, 0, 0, 0);
    end
    for (int j = 1; j <= 6; j++)
      go("mov_left", mk(MOV, 8'd1), 1, 0, 0, 100, (j < 5) ? 418 : 416, 340, 0, 0, 0);
    go("mov_drop",    mk(MOV, 8'd1), 0, 0, 0, 100, 416, 340, 0, 0, 0);
    go("mov_restart", mk(MOV, 8'd1), 1, 0, 0, 100, 414, 340, 0, 0, 0);
    go("mov_halt",    16'h0000,      0, 0, 0, 100, 414, 340, 0, 0, 0);
    go("mov_up",      mk(MOV, 8'd0), 1, 0, 0, 100, 414, 338, 0, 0, 0);
    go("mov_gap",     16'h0000,      0, 0, 0, 100, 414, 338, 0, 0, 0);
    go("mov_down_hi", mk(MOV, 8'hFE), 1, 0, 0, 100, 414, 340, 0, 0, 0);

    // Reset in the middle of an invulnerability window.
    go("dpy10",         mk(DPY, 8'd10), 0, 1, 0, 90, 414, 340, 0, 1, 1);
    go("hpy_in_invuln", mk(HPY, 8'd5),  0, 1, 0, 95, 414, 340, 0, 1, 1);
    go("reset_mid",     16'h0000,       0, 0, 1,  0, 320, 340, 0, 0, 0);
    go("post_reset",    16'h0000,       0, 0, 0,  0, 320, 340, 0, 0, 0);
    go("hpy_not_alive", mk(HPY, 8'd10), 0, 1, 0,  0, 320, 340, 0, 0, 0);
    go("mov_not_alive", mk(MOV, 8'd3),  1, 0, 0,  0, 320, 340, 0, 0, 0);

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      errors += sb.size();
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/player_executor.md
# player_executor

Back-end executor for the 16-bit player instruction word issued by the game control FSM. Decodes opcode and operand, applies HP changes with saturation, moves the player sprite inside the dodge box at a rate-limited step, and enforces an invulnerability window after damage. Reports `is_death` and a damage-done pulse back to the FSM, and feeds HP and position to the renderer.

## Interface
- `MAX_HP`, 100: HP ceiling. Range 1..255.
- `BOX_X_MIN` / `BOX_X_MAX`, 220 / 420: horizontal clamp limits in pixels, inclusive.
- `BOX_Y_MIN` / `BOX_Y_MAX`, 260 / 420: vertical clamp limits in pixels, inclusive.
- `MOVE_STEP`, 2: pixels per move tick.
- `MOVE_DIV`, 250000: clk cycles between move ticks while a move is held.
- `INVULN_CYCLES`, 50000000: length of the invulnerability window after damage.
- `clk`  in  1  system clock. The design has one clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `playerInstruction`  in  16  instruction word: [15:12] opcode, [11:4] operand, [3:0] ignored.
- `isMove`  in  1  move qualifier. A `MOV` instruction takes effect only while this is high.
- `startDmg`  in  1  single-cycle strobe that executes an `HPY` or `DPY` instruction.
- `hp`  out  8  current player HP.
- `pos_x`  out  10  player x position.
- `pos_y`  out  10  player y position.
- `isDeath`  out  1  level. High while the player is dead.
- `dmg_done`  out  1  one-cycle pulse acknowledging an applied `HPY`/`DPY`.
- `invuln`  out  1  high during the invulnerability window.

## Operation
- **Opcodes** (shared package):
  - `HPY`=1: heal by operand.
  - `DPY`=2: damage by operand.
  - `IDG`=3 and `SDG`=4: reserved, treated as no-op.
  - `MOV`=5: move.
  - `SHP`=6: set HP.
  - 0 and 7..15: no-op.
- **`SHP`**, level-sensitive, no strobe needed:
  - `hp` = min(operand, `MAX_HP`).
  - Position set to box centre: (`BOX_X_MIN`+`BOX_X_MAX`)/2, (`BOX_Y_MIN`+`BOX_Y_MAX`)/2.
  - `isDeath`=0, `alive`=1 (internal flag).
  - `invuln` cleared, FSM forced to `IDLE`.
  - While `SHP` is held, it re-applies every cycle.
- **`DPY`** (on `startDmg`, FSM in `IDLE`, `alive`=1): `hp` = `hp` − operand, saturating at 0. If the result is 0: `isDeath`=1, `alive`=0.
- **`HPY`** (on `startDmg`, `alive`=1): `hp` = min(`hp` + operand, `MAX_HP`), computed in 9 bits. Accepted in any FSM state.
- **Strobe conditions that do nothing:**
  - `startDmg` with any other opcode: ignored, no `dmg_done`.
  - `startDmg` while `alive`=0: ignored.
- **FSM**, states `IDLE`, `INVULN`:
  - `IDLE` → `INVULN` on an accepted `DPY` that leaves `hp` > 0. The counter loads `INVULN_CYCLES`−1.
  - `INVULN` → `IDLE` when the counter reaches 0.
  - A `DPY` strobe in `INVULN` is dropped: no HP change, no `dmg_done`.
- **`MOV`**:
  - Direction is operand[1:0]: 0 up (y−), 1 left (x−), 2 down (y+), 3 right (x+). Operand[7:2] is ignored.
  - Move counter:
    - `isMove`=0 or opcode≠`MOV`: counter := 0.
    - Otherwise, counter==0: apply the step and load `MOVE_DIV`−1.
    - Otherwise: decrement.
  - Step result is clamped to [MIN, MAX] on the moving axis, using 11-bit signed intermediates.
  - Moves are allowed in `INVULN` and are blocked while `alive`=0.

## Timing
- **Reset values:**
  - `hp`=0, `isDeath`=0, `dmg_done`=0, `invuln`=0.
  - `pos` = box centre.
  - `alive`=0, FSM in `IDLE`, all counters 0.
- **Registered outputs:** all outputs update on the clk edge after the inputs are sampled, so latency is 1 cycle.
- **`dmg_done`** is high exactly on the cycle `hp` shows the new value.
- **`invuln`** rises in that same cycle and stays high for `INVULN_CYCLES` cycles.
- **First move:** a held `MOV` moves on the first qualified cycle, then every `MOVE_DIV` cycles.
- **Priority, highest first:** `reset` > `SHP` > strobed `HPY`/`DPY` > `MOV`.
- **Reset mid-window:** `reset` during `INVULN` or mid-move restores all reset values next cycle.
- **Death output:** `isDeath` stays high until `SHP` or `reset`.

## Structure
- **`player_pkg`:**
  - Opcode constants.
  - Direction constants.
  - Instruction field slices: `OPC_HI`/`OPC_LO`, `ARG_HI`/`ARG_LO`.
  - FSM state enum.
  - This package is shared with the control FSM.
- **Sub-module `hp_sat_alu`:** combinational saturating add/sub, with inputs `hp`, operand, op select and `MAX_HP`, and outputs new HP and a zero flag.
- **Top level:** FSM, invulnerability counter, move divider and position clamp.

## Test plan
Run with `MAX_HP`=100, `MOVE_DIV`=4, `INVULN_CYCLES`=8, `MOVE_STEP`=2.

1. **`SHP` 100 then damage:** one cycle of `SHP` 100 → `hp`=100, pos=(320,340). Then `startDmg` + `DPY` 30 → next cycle `hp`=70, `dmg_done`=1, `invuln` high for 8 cycles.
2. **Damage during invulnerability:** `DPY` 30 strobed 3 cycles after scenario 1's hit → `hp` stays 70, no `dmg_done`. After `invuln` falls, `DPY` 80 → `hp`=0, `isDeath`=1. Further `DPY`/`HPY` ignored.
3. **Heal saturation:** `hp`=95, `HPY` 10 → `hp`=100. `HPY` 255 with `hp`=1 → `hp`=100, checking the 9-bit path.
4. **Move clamp:** `MOV` right with `isMove` held 400 cycles from x=320 → x increments by 2 every 4 cycles, starting on cycle 1, and stops at 420. Dropping `isMove` halts motion immediately.
5. **Move while dead or after reset:** `MOV` while `isDeath`=1 → position unchanged. `reset` during `INVULN` → all outputs at reset values next cycle, `invuln`=0.
6. **Strobe with non-damage opcode:** `startDmg` with a `MOV` or `IDG` opcode → no `hp` change, no `dmg_done`.
